// File: rtl/sim_clint_model.sv
// Simulation CLINT: msip/mtimecmp/mtime register block with a valid/ready access port.
// Optional mtime-triggered interrupt injector enabled by SIM_CLINT_IRQ_INJECT_EN.

module sim_clint_hart #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] mtime,
    input  logic [XLEN-1:0] wdata,
    input  logic            wr_msip,
    input  logic            wr_cmp,
`ifdef SIM_CLINT_IRQ_INJECT_EN
    input  logic            wr_inj_at,
    input  logic            wr_inj_ctl,
    output logic [XLEN-1:0] inj_at,
    output logic [1:0]      inj_ctl,
`endif
    input  logic            ext_mei,
    input  logic            ext_sei,
    output logic            msip,
    output logic [XLEN-1:0] mtimecmp,
    output logic            mti,
    output logic            mei,
    output logic            sei
);
    logic [1:0] mei_sync;
    logic [1:0] sei_sync;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
            mti      <= 1'b0;
            mei_sync <= 2'b00;
            sei_sync <= 2'b00;
        end else begin
            if (wr_msip) msip <= wdata[0];
            if (wr_cmp)  mtimecmp <= wdata;
            mti      <= (mtime >= mtimecmp);
            mei_sync <= {mei_sync[0], ext_mei};
            sei_sync <= {sei_sync[0], ext_sei};
        end
    end

`ifdef SIM_CLINT_IRQ_INJECT_EN
    // hit[0] drives mei, hit[1] drives sei; sticky until the control word is cleared
    logic [1:0] hit;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inj_at  <= '1;
            inj_ctl <= 2'b00;
            hit     <= 2'b00;
        end else begin
            if (wr_inj_at) inj_at <= wdata;
            if (wr_inj_ctl) begin
                inj_ctl <= wdata[1:0];
                if (wdata[1:0] == 2'b00) hit <= 2'b00;
            end else if (mtime == inj_at) begin
                hit <= hit | inj_ctl;
            end
        end
    end

    assign mei = mei_sync[1] | hit[0];
    assign sei = sei_sync[1] | hit[1];
`else
    assign mei = mei_sync[1];
    assign sei = sei_sync[1];
`endif
endmodule

module sim_clint_model #(
    parameter int              XLEN       = 64,
    parameter int              NHART      = 2,
    parameter int              TICK_DIV   = 1,
    parameter logic [XLEN-1:0] MTIME_INIT = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [15:0]      req_addr_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_rdata_o,
    output logic             rsp_err_o,
    input  logic [NHART-1:0] ext_mei_i,
    input  logic [NHART-1:0] ext_sei_i,
    output logic [NHART-1:0] mei_o,
    output logic [NHART-1:0] sei_o,
    output logic [NHART-1:0] msi_o,
    output logic [NHART-1:0] mti_o,
    output logic [XLEN-1:0]  mtime_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;

    logic [PW-1:0]   presc;
    logic [XLEN-1:0] mtime;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic [NHART-1:0]           msip_vec;
    logic [NHART-1:0][XLEN-1:0] cmp_vec;
`ifdef SIM_CLINT_IRQ_INJECT_EN
    logic [NHART-1:0][XLEN-1:0] inj_at_vec;
    logic [NHART-1:0][1:0]      inj_ctl_vec;
    logic                       in_inj_at;
    logic                       in_inj_ctl;
`endif

    logic            accept;
    logic            aligned;
    logic            hart_ok;
    logic [HW-1:0]   hsel;
    logic            in_msip;
    logic            in_cmp;
    logic            in_mtime;
    logic            rd_err;
    logic [XLEN-1:0] rd_data;
    logic            wr_en;

    assign req_ready_o = !rsp_valid || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // Region decode on 64-byte windows; the hart index lives in addr[5:3]
    assign aligned  = (req_addr_i[2:0] == 3'b000);
    assign hart_ok  = (int'(req_addr_i[5:3]) < NHART);
    assign hsel     = req_addr_i[3 +: HW];
    assign in_msip  = (req_addr_i[15:6] == 10'h000) && hart_ok;
    assign in_cmp   = (req_addr_i[15:6] == 10'h100) && hart_ok;
    assign in_mtime = (req_addr_i == 16'hBFF8);
`ifdef SIM_CLINT_IRQ_INJECT_EN
    assign in_inj_at  = (req_addr_i[15:6] == 10'h200) && hart_ok;
    assign in_inj_ctl = (req_addr_i[15:6] == 10'h220) && hart_ok;
`endif

    always_comb begin
        rd_err  = 1'b1;
        rd_data = '0;
        if (aligned) begin
            if (in_msip) begin
                rd_err  = 1'b0;
                rd_data = {{(XLEN-1){1'b0}}, msip_vec[hsel]};
            end else if (in_cmp) begin
                rd_err  = 1'b0;
                rd_data = cmp_vec[hsel];
            end else if (in_mtime) begin
                rd_err  = 1'b0;
                rd_data = mtime;
`ifdef SIM_CLINT_IRQ_INJECT_EN
            end else if (in_inj_at) begin
                rd_err  = 1'b0;
                rd_data = inj_at_vec[hsel];
            end else if (in_inj_ctl) begin
                rd_err  = 1'b0;
                rd_data = {{(XLEN-2){1'b0}}, inj_ctl_vec[hsel]};
`endif
            end
        end
    end

    assign wr_en = accept && req_write_i && !rd_err;

    // A write to mtime restarts the prescaler and wins over the tick
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mtime <= MTIME_INIT;
            presc <= '0;
        end else if (wr_en && in_mtime) begin
            mtime <= req_wdata_i;
            presc <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            mtime <= mtime + XLEN'(1);
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_write_i ? '0 : rd_data;
            rsp_err   <= rd_err;
        end else if (rsp_ready_i) begin
            rsp_valid <= 1'b0;
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        logic hit;
        assign hit = (req_addr_i[5:3] == 3'(h));

        sim_clint_hart #(.XLEN(XLEN)) u_hart (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .mtime      (mtime),
            .wdata      (req_wdata_i),
            .wr_msip    (wr_en && in_msip && hit),
            .wr_cmp     (wr_en && in_cmp && hit),
`ifdef SIM_CLINT_IRQ_INJECT_EN
            .wr_inj_at  (wr_en && in_inj_at && hit),
            .wr_inj_ctl (wr_en && in_inj_ctl && hit),
            .inj_at     (inj_at_vec[h]),
            .inj_ctl    (inj_ctl_vec[h]),
`endif
            .ext_mei    (ext_mei_i[h]),
            .ext_sei    (ext_sei_i[h]),
            .msip       (msip_vec[h]),
            .mtimecmp   (cmp_vec[h]),
            .mti        (mti_o[h]),
            .mei        (mei_o[h]),
            .sei        (sei_o[h])
        );
    end

    assign msi_o       = msip_vec;
    assign mtime_o     = mtime;
    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_rdata;
    assign rsp_err_o   = rsp_err;
endmodule
